// File: rtl/dcache_pkg.sv
// Shared definitions for the data cache: default geometry, derived field widths,
// controller state encoding and the store byte-merge helper.
package dcache_pkg;

  localparam int DCACHE_ADDR_BITS = 12;
  localparam int DCACHE_LINES     = 16;
  localparam int DCACHE_WPL       = 4;

  localparam int DCACHE_OFF_W = $clog2(DCACHE_WPL);
  localparam int DCACHE_IDX_W = $clog2(DCACHE_LINES);
  localparam int DCACHE_TAG_W = DCACHE_ADDR_BITS - 2 - DCACHE_OFF_W - DCACHE_IDX_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RESP,
    ST_WRITE
  } dcache_state_e;

  // Replace only the enabled byte lanes of old_word with those of new_word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dcache_tag_array.sv
// Storage for the direct-mapped cache: per-line valid/tag plus data words.
// Reads are combinational; writes are clocked; valid bits clear asynchronously on reset.
module dcache_tag_array #(
  parameter int LINES = 16,
  parameter int WPL   = 4,
  parameter int TAG_W = 4,
  parameter int IDX_W = $clog2(LINES),
  parameter int OFF_W = $clog2(WPL)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_index,
  input  logic [OFF_W-1:0] rd_offset,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_index,
  input  logic             set_en,
  input  logic [IDX_W-1:0] set_index,
  input  logic [TAG_W-1:0] set_tag,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [OFF_W-1:0] wr_offset,
  input  logic [31:0]      wr_data
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES*WPL];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int i = 0; i < LINES; i++) tag_q[i] <= '0;
    end else begin
      if (clr_en) valid_q[clr_index] <= 1'b0;
      if (set_en) begin
        valid_q[set_index] <= 1'b1;
        tag_q[set_index]   <= set_tag;
      end
    end
  end

  // Data words need no reset: a word is only ever returned from a valid line.
  always_ff @(posedge clock) begin
    if (wr_en) data_q[{wr_index, wr_offset}] <= wr_data;
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[{rd_index, rd_offset}];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Loads hit in zero cycles; misses fill the whole line, stores always go to backing memory.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_BITS      = DCACHE_ADDR_BITS,
  parameter int LINES          = DCACHE_LINES,
  parameter int WORDS_PER_LINE = DCACHE_WPL
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        proc_ren,
  input  logic        proc_wen,
  input  logic [31:0] proc_addr,
  input  logic [3:0]  proc_mask,
  input  logic [31:0] proc_wdata,
  output logic [31:0] proc_rdata,
  output logic        proc_read_done,
  output logic        proc_write_done,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_mask,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(LINES);
  localparam int WA_W  = ADDR_BITS - 2;
  localparam int TAG_W = WA_W - IDX_W - OFF_W;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

  dcache_state_e    state_q, state_d;
  logic [WA_W-1:0]  cap_waddr_q;
  logic [3:0]       cap_mask_q;
  logic [31:0]      cap_wdata_q;
  logic [OFF_W-1:0] count_q;

  logic             capture, count_clr, count_inc;
  logic [WA_W-1:0]  req_waddr, look_waddr, fill_waddr;
  logic [OFF_W-1:0] look_off, cap_off, wr_offset;
  logic [IDX_W-1:0] look_idx, cap_idx;
  logic [TAG_W-1:0] look_tag, cap_tag, rd_tag;
  logic             rd_valid, hit;
  logic [31:0]      rd_data, wr_data;
  logic             clr_en, set_en, wr_en;
  logic             addr_unused;

  assign addr_unused = ^{proc_addr[31:ADDR_BITS], proc_addr[1:0]};

  // In IDLE the array is probed with the live request; afterwards only the captured one matters.
  assign req_waddr  = proc_addr[ADDR_BITS-1:2];
  assign look_waddr = (state_q == ST_IDLE) ? req_waddr : cap_waddr_q;
  assign look_off   = look_waddr[OFF_W-1:0];
  assign look_idx   = look_waddr[OFF_W +: IDX_W];
  assign look_tag   = look_waddr[WA_W-1 -: TAG_W];
  assign cap_off    = cap_waddr_q[OFF_W-1:0];
  assign cap_idx    = cap_waddr_q[OFF_W +: IDX_W];
  assign cap_tag    = cap_waddr_q[WA_W-1 -: TAG_W];
  assign fill_waddr = {cap_tag, cap_idx, count_q};
  assign hit        = rd_valid && (rd_tag == look_tag);

  dcache_tag_array #(
    .LINES (LINES),
    .WPL   (WORDS_PER_LINE),
    .TAG_W (TAG_W),
    .IDX_W (IDX_W),
    .OFF_W (OFF_W)
  ) u_array (
    .clock     (clock),
    .reset     (reset),
    .rd_index  (look_idx),
    .rd_offset (look_off),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .clr_en    (clr_en),
    .clr_index (look_idx),
    .set_en    (set_en),
    .set_index (cap_idx),
    .set_tag   (cap_tag),
    .wr_en     (wr_en),
    .wr_index  (cap_idx),
    .wr_offset (wr_offset),
    .wr_data   (wr_data)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cap_waddr_q <= '0;
      cap_mask_q  <= '0;
      cap_wdata_q <= '0;
      count_q     <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        cap_waddr_q <= req_waddr;
        cap_mask_q  <= proc_mask;
        cap_wdata_q <= proc_wdata;
      end
      if (count_clr)      count_q <= '0;
      else if (count_inc) count_q <= count_q + 1'b1;
    end
  end

  always_comb begin
    state_d         = state_q;
    stall           = 1'b0;
    proc_read_done  = 1'b0;
    proc_write_done = 1'b0;
    proc_rdata      = '0;
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    mem_mask        = '0;
    capture         = 1'b0;
    count_clr       = 1'b0;
    count_inc       = 1'b0;
    clr_en          = 1'b0;
    set_en          = 1'b0;
    wr_en           = 1'b0;
    wr_offset       = count_q;
    wr_data         = mem_rdata;

    case (state_q)
      ST_IDLE: begin
        if (proc_wen) begin
          stall   = 1'b1;
          capture = 1'b1;
          state_d = ST_WRITE;
        end else if (proc_ren) begin
          if (hit) begin
            proc_read_done = 1'b1;
            proc_rdata     = rd_data;
          end else begin
            // The line is invalidated up front so an interrupted fill never leaves it valid.
            stall     = 1'b1;
            capture   = 1'b1;
            clr_en    = 1'b1;
            count_clr = 1'b1;
            state_d   = ST_FILL;
          end
        end
      end

      ST_FILL: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {{(32-ADDR_BITS){1'b0}}, fill_waddr, 2'b00};
        if (mem_ack) begin
          wr_en     = 1'b1;
          count_inc = 1'b1;
          if (count_q == LAST_WORD) begin
            set_en  = 1'b1;
            state_d = ST_RESP;
          end
        end
      end

      ST_RESP: begin
        proc_read_done = 1'b1;
        proc_rdata     = rd_data;
        state_d        = ST_IDLE;
      end

      ST_WRITE: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {{(32-ADDR_BITS){1'b0}}, cap_waddr_q, 2'b00};
        mem_wdata = cap_wdata_q;
        mem_mask  = cap_mask_q;
        if (mem_ack) begin
          stall           = 1'b0;
          proc_write_done = 1'b1;
          state_d         = ST_IDLE;
          // Write-through keeps a resident copy coherent; a miss leaves the cache untouched.
          if (hit) begin
            wr_en     = 1'b1;
            wr_offset = cap_off;
            wr_data   = merge_bytes(rd_data, cap_wdata_q, cap_mask_q);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule
